// File: rtl/reg_timeout_pkg.sv
// reg_timeout_pkg
// Shared types for the register-bus timeout cut:
//   - state_e     : FSM state encoding
//   - def_req_t   : default regbus request struct  {addr, write, wdata, wstrb, valid}
//   - def_rsp_t   : default regbus response struct {rdata, error, ready}
//   - cnt_width() : width of the watchdog counter for a given TIMEOUT
package reg_timeout_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FWD     = 3'd1,
        RESP    = 3'd2,
        TO_RESP = 3'd3,
        DRAIN   = 3'd4
    } state_e;

    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;

    typedef struct packed {
        logic [DEF_AW-1:0]   addr;
        logic                write;
        logic [DEF_DW-1:0]   wdata;
        logic [DEF_DW/8-1:0] wstrb;
        logic                valid;
    } def_req_t;

    typedef struct packed {
        logic [DEF_DW-1:0] rdata;
        logic              error;
        logic              ready;
    } def_rsp_t;

    // $clog2(TIMEOUT+1) bits, never less than one bit (TIMEOUT=0 still needs a flop).
    function automatic int cnt_width(input int timeout);
        if (timeout > 0) begin
            return $clog2(timeout + 1);
        end
        return 1;
    endfunction

endpackage

// File: rtl/reg_timeout_cut.sv
// reg_timeout_cut
// Register-bus pipeline cut with a per-transaction watchdog. Each upstream request is
// registered once and forwarded downstream; the downstream response is registered and
// returned upstream. A downstream that does not answer within TIMEOUT cycles is answered
// upstream with error=1 / rdata=ERR_DATA, and the late response is drained and discarded.
//
// Handshake (both sides): a requester raises valid with a payload and holds both stable
// until the cycle in which the responder drives ready=1; the transfer happens at the
// rising edge ending that cycle. ready is a single-cycle pulse carrying rdata/error.
//
// Ports
//   clk_i      in   clock, rising edge
//   rst_i      in   asynchronous active-high reset
//   reg_req_i  in   upstream request
//   reg_rsp_o  out  upstream response
//   reg_req_o  out  downstream request
//   reg_rsp_i  in   downstream response
//   timeout_o  out  one-cycle pulse per timed-out transaction
//   busy_o     out  high whenever the FSM is not IDLE
//   state_o    out  current FSM state (debug)
module reg_timeout_cut
    import reg_timeout_pkg::*;
#(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter int          TIMEOUT    = 256,
    parameter logic [63:0] ERR_DATA   = 64'hBADCAB1E,
    parameter type         reg_req_t  = def_req_t,
    parameter type         reg_rsp_t  = def_rsp_t
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  reg_req_t reg_req_i,
    output reg_rsp_t reg_rsp_o,
    output reg_req_t reg_req_o,
    input  reg_rsp_t reg_rsp_i,
    output logic     timeout_o,
    output logic     busy_o,
    output state_e   state_o
);

    if (ADDR_WIDTH <= 0) begin : g_bad_addr_width
        $error("reg_timeout_cut: ADDR_WIDTH must be > 0");
    end
    if (DATA_WIDTH <= 0 || (DATA_WIDTH % 8) != 0) begin : g_bad_data_width
        $error("reg_timeout_cut: DATA_WIDTH must be > 0 and a multiple of 8");
    end

    localparam int                    CNT_W     = cnt_width(TIMEOUT);
    localparam int                    STRB_W    = DATA_WIDTH / 8;
    localparam logic [CNT_W-1:0]      CNT_LIMIT = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [DATA_WIDTH-1:0] ERR_RDATA = DATA_WIDTH'(ERR_DATA);

    state_e                  r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_write;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [STRB_W-1:0]       r_wstrb;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_error;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_rdata <= '0;
            r_error <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (reg_req_i.valid) begin
                        r_addr  <= reg_req_i.addr;
                        r_write <= reg_req_i.write;
                        r_wdata <= reg_req_i.wdata;
                        r_wstrb <= reg_req_i.wstrb;
                        r_cnt   <= '0;
                        r_state <= FWD;
                    end
                end
                FWD: begin
                    // A ready arriving in the limit cycle still wins over the abort.
                    if (reg_rsp_i.ready) begin
                        r_rdata <= r_write ? '0 : reg_rsp_i.rdata;
                        r_error <= reg_rsp_i.error;
                        r_state <= RESP;
                    end else if (TIMEOUT != 0 && r_cnt == CNT_LIMIT) begin
                        r_state <= TO_RESP;
                    end else if (r_cnt != '1) begin
                        // Saturate: with the watchdog disabled the counter must not wrap.
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                TO_RESP: begin
                    r_state <= reg_rsp_i.ready ? IDLE : DRAIN;
                end
                DRAIN: begin
                    // Late downstream answer is swallowed; upstream was already answered.
                    if (reg_rsp_i.ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode the registered state so an async reset clears them immediately.
    always_comb begin
        reg_req_o = '0;
        reg_rsp_o = '0;
        timeout_o = (r_state == TO_RESP);
        busy_o    = (r_state != IDLE);
        state_o   = r_state;

        if (r_state == FWD || r_state == TO_RESP || r_state == DRAIN) begin
            reg_req_o.addr  = r_addr;
            reg_req_o.write = r_write;
            reg_req_o.wdata = r_wdata;
            reg_req_o.wstrb = r_wstrb;
            reg_req_o.valid = 1'b1;
        end

        if (r_state == RESP) begin
            reg_rsp_o.rdata = r_rdata;
            reg_rsp_o.error = r_error;
            reg_rsp_o.ready = 1'b1;
        end else if (r_state == TO_RESP) begin
            reg_rsp_o.rdata = ERR_RDATA;
            reg_rsp_o.error = 1'b1;
            reg_rsp_o.ready = 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_timeout_cut.sv
module tb_reg_timeout_cut;
  import reg_timeout_pkg::*;

  localparam int          T   = 4;
  localparam logic [31:0] ERR = 32'hBADCAB1E;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  def_req_t up_req, dn_req, up_req1, dn_req1;
  def_rsp_t up_rsp, dn_rsp, up_rsp1, dn_rsp1;
  logic     to0, busy0, to1, busy1;
  state_e   st0, st1;

  reg_timeout_cut #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(T)) u_dut0 (
    .clk_i(clk), .rst_i(rst),
    .reg_req_i(up_req), .reg_rsp_o(up_rsp),
    .reg_req_o(dn_req), .reg_rsp_i(dn_rsp),
    .timeout_o(to0), .busy_o(busy0), .state_o(st0)
  );

  reg_timeout_cut #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(0)) u_dut1 (
    .clk_i(clk), .rst_i(rst),
    .reg_req_i(up_req1), .reg_rsp_o(up_rsp1),
    .reg_req_o(dn_req1), .reg_rsp_i(dn_rsp1),
    .timeout_o(to1), .busy_o(busy1), .state_o(st1)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        to;
    int          issue;
    int          lat;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          wait_n;
    logic [31:0] rdata;
    logic        err;
  } ds_t;
  ds_t ds_q[$];

  int to_cnt0 = 0;
  int to_cnt1 = 0;
  always @(negedge clk) begin
    if (to0 === 1'b1) to_cnt0++;
    if (to1 === 1'b1) to_cnt1++;
  end

  // Upstream monitor: pops an expectation whenever the cut answers upstream.
  exp_t e;
  always @(negedge clk) begin
    if (!rst) begin
      if (up_rsp.ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_up_rsp", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("up_rdata", up_rsp.rdata, e.rdata);
          check("up_error", up_rsp.error, e.err);
          check("up_timeout_o", to0, e.to);
          check("up_latency", cyc - e.issue, e.lat);
        end
      end else begin
        check("up_rsp_zero_when_not_ready", {up_rsp.rdata, up_rsp.error}, 0);
        check("timeout_without_rsp", to0, 0);
      end
    end
  end

  // Downstream model: answers each forwarded request after wait_n extra cycles of valid.
  ds_t      cur;
  logic     ds_in = 1'b0;
  int       ds_cnt = 0;
  def_req_t held;
  initial begin
    dn_rsp = '0;
    forever begin
      @(posedge clk);
      #1;
      dn_rsp = '0;
      if (dn_req.valid === 1'b1) begin
        if (!ds_in) begin
          if (ds_q.size() == 0) begin
            check("unexpected_dn_req", 1, 0);
            cur = '{addr: 0, write: 0, wdata: 0, wstrb: 0, wait_n: 1000000, rdata: 0, err: 0};
          end else begin
            cur = ds_q.pop_front();
            check("dn_addr", dn_req.addr, cur.addr);
            check("dn_write", dn_req.write, cur.write);
            check("dn_wdata", dn_req.wdata, cur.wdata);
            check("dn_wstrb", dn_req.wstrb, cur.wstrb);
          end
          ds_in  = 1'b1;
          ds_cnt = 0;
          held   = dn_req;
        end else begin
          ds_cnt++;
          check("dn_payload_stable", (dn_req === held), 1);
          check("busy_while_dn_valid", busy0, 1);
        end
        if (ds_cnt == cur.wait_n) begin
          dn_rsp.rdata = cur.rdata;
          dn_rsp.error = cur.err;
          dn_rsp.ready = 1'b1;
        end
      end else begin
        ds_in = 1'b0;
      end
    end
  end

  // ---------------- driver ----------------
  // Called at posedge+1; returns at posedge+1 of the cycle after the upstream handshake.
  task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] wstrb, input int wait_n, input logic [31:0] ds_rdata,
                     input logic ds_err, input logic [31:0] exp_rdata, input logic exp_err,
                     input logic exp_to, input int exp_lat);
    int n;
    ds_q.push_back('{addr: addr, write: wr, wdata: wdata, wstrb: wstrb,
                     wait_n: wait_n, rdata: ds_rdata, err: ds_err});
    exp_q.push_back('{rdata: exp_rdata, err: exp_err, to: exp_to, issue: cyc, lat: exp_lat});
    up_req.addr  = addr;
    up_req.write = wr;
    up_req.wdata = wdata;
    up_req.wstrb = wstrb;
    up_req.valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (up_rsp.ready !== 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (up_rsp.ready !== 1'b1) check("handshake_bound", 0, 1);
    @(posedge clk);
    #1;
    up_req = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int  n;
    logic bad;
    up_req  = '0;
    up_req1 = '0;
    dn_rsp1 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dn_req", dn_req, 0);
    check("rst_up_rsp", up_rsp, 0);
    check("rst_timeout", to0, 0);
    check("rst_busy", busy0, 0);
    check("rst_state", st0, IDLE);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // read, ready in first downstream cycle
    txn(1'b0, 32'h20, 32'h0, 4'hF, 0, 32'h1234, 1'b0, 32'h1234, 1'b0, 1'b0, 2);
    // write, two wait cycles; write returns rdata=0
    txn(1'b1, 32'h10, 32'hA5A5A5A5, 4'b0101, 2, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1'b0, 4);
    // ready exactly in the limit cycle: normal response
    txn(1'b0, 32'h30, 32'h0, 4'hF, T-1, 32'hCAFE, 1'b0, 32'hCAFE, 1'b0, 1'b0, T+1);
    // read error passes through
    txn(1'b0, 32'h34, 32'h0, 4'hF, 1, 32'h77, 1'b1, 32'h77, 1'b1, 1'b0, 3);
    // write with wstrb=0, error passes through
    txn(1'b1, 32'h40, 32'h11223344, 4'b0000, 0, 32'h99, 1'b1, 32'h0, 1'b1, 1'b0, 2);
    // timeout, downstream answers in the TO_RESP cycle
    txn(1'b0, 32'h50, 32'h0, 4'hF, T, 32'h55, 1'b0, ERR, 1'b1, 1'b1, T+1);
    // timeout, downstream answers 3 cycles after TO_RESP; a read queued during DRAIN
    txn(1'b0, 32'h60, 32'h0, 4'hF, T+3, 32'h66, 1'b1, ERR, 1'b1, 1'b1, T+1);
    check("drain_busy", busy0, 1);
    check("drain_state", st0, DRAIN);
    txn(1'b0, 32'h64, 32'h0, 4'hF, 0, 32'hABCD, 1'b0, 32'hABCD, 1'b0, 1'b0, 5);

    // reset during FWD
    ds_q.push_back('{addr: 32'h70, write: 1'b0, wdata: 0, wstrb: 4'hF,
                     wait_n: 100, rdata: 0, err: 0});
    up_req.addr  = 32'h70;
    up_req.wstrb = 4'hF;
    up_req.valid = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("fwd_before_rst", dn_req.valid, 1);
    rst    = 1'b1;
    up_req = '0;
    #1;
    check("rst_mid_dn_valid", dn_req.valid, 0);
    check("rst_mid_busy", busy0, 0);
    check("rst_mid_up_rsp", up_rsp, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    txn(1'b0, 32'h80, 32'h0, 4'hF, 1, 32'h4242, 1'b0, 32'h4242, 1'b0, 1'b0, 3);

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      n++;
      @(posedge clk);
    end
    check("exp_q_drained", exp_q.size(), 0);
    check("timeout_pulses", to_cnt0, 2);

    // TIMEOUT=0: a 1000-cycle stall still completes normally
    up_req1.addr  = 32'h90;
    up_req1.wstrb = 4'hF;
    up_req1.valid = 1'b1;
    bad = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 1000; i++) begin
      if (up_rsp1.ready !== 1'b0 || to1 !== 1'b0 || dn_req1.valid !== 1'b1) bad = 1'b1;
      @(posedge clk);
      #1;
    end
    check("t0_stall_clean", bad, 0);
    check("t0_dn_addr", dn_req1.addr, 32'h90);
    dn_rsp1.rdata = 32'h5A5A;
    dn_rsp1.ready = 1'b1;
    @(posedge clk);
    #1;
    dn_rsp1 = '0;
    check("t0_up_ready", up_rsp1.ready, 1);
    check("t0_up_rdata", up_rsp1.rdata, 32'h5A5A);
    check("t0_up_error", up_rsp1.error, 0);
    check("t0_timeout", to1, 0);
    @(posedge clk);
    #1;
    up_req1 = '0;
    check("t0_idle_after", busy1, 0);
    check("t0_timeout_pulses", to_cnt1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

endmodule
